// File: rtl/tt_pkg.sv
// Shared types and constants for the truth-table identifier.
// Holds the state encoding, gate classes and function codes.
package tt_pkg;

  typedef enum logic [1:0] {
    S_CAPTURE,
    S_DONE,
    S_ERROR,
    S_TIMEOUT
  } tt_state_e;

  localparam logic [2:0] GID_UNKNOWN = 3'd0;
  localparam logic [2:0] GID_AND     = 3'd1;
  localparam logic [2:0] GID_OR      = 3'd2;
  localparam logic [2:0] GID_NAND    = 3'd3;
  localparam logic [2:0] GID_NOR     = 3'd4;
  localparam logic [2:0] GID_XOR     = 3'd5;
  localparam logic [2:0] GID_XNOR    = 3'd6;
  localparam logic [2:0] GID_ANDN    = 3'd7;

  localparam logic [3:0] FC_AND  = 4'h8;
  localparam logic [3:0] FC_OR   = 4'hE;
  localparam logic [3:0] FC_NAND = 4'h7;
  localparam logic [3:0] FC_NOR  = 4'h1;
  localparam logic [3:0] FC_XOR  = 4'h6;
  localparam logic [3:0] FC_XNOR = 4'h9;
  localparam logic [3:0] FC_ANDN = 4'h2;

endpackage

// File: rtl/tt_classify.sv
// Combinational map from a 4-bit truth table to a gate class.
// Codes outside the standard set fall back to UNKNOWN.
module tt_classify
  import tt_pkg::*;
(
  input  logic [3:0] code,
  output logic [2:0] gate_id
);

  // Match the code against each known gate table
  always_comb begin
    gate_id = GID_UNKNOWN;
    unique case (1'b1)
      (code == FC_AND):  gate_id = GID_AND;
      (code == FC_OR):   gate_id = GID_OR;
      (code == FC_NAND): gate_id = GID_NAND;
      (code == FC_NOR):  gate_id = GID_NOR;
      (code == FC_XOR):  gate_id = GID_XOR;
      (code == FC_XNOR): gate_id = GID_XNOR;
      (code == FC_ANDN): gate_id = GID_ANDN;
      default:           gate_id = GID_UNKNOWN;
    endcase
  end

endmodule

// File: rtl/truth_table_identifier.sv
// Rebuilds a 2-input gate truth table from observed samples.
// Reports the code and class once all four inputs are covered.
module truth_table_identifier
  import tt_pkg::*;
#(
  parameter int MAX_SAMPLES = 16,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       a,
  input  logic       b,
  input  logic       s,
  output logic       done,
  output logic [3:0] func_code,
  output logic [2:0] gate_id,
  output logic       error,
  output logic       timeout
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_SAMPLES);

  tt_state_e        state_q, state_d;
  logic [3:0]       table_q, table_d;
  logic [3:0]       seen_q, seen_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [3:0]       func_code_q, func_code_d;
  logic [2:0]       gate_id_q, gate_id_d;

  logic             accept;
  logic [1:0]       idx;
  logic [3:0]       table_n;
  logic [3:0]       seen_n;
  logic             conflict;
  logic [CNT_W-1:0] count_n;
  logic [2:0]       cls_id;

  assign in_ready = (state_q == S_CAPTURE);
  assign accept   = in_valid && in_ready;
  assign idx      = {a, b};

  // Effect of the current sample on table, mask and count
  always_comb begin
    table_n = table_q;
    if (!seen_q[idx]) table_n[idx] = s;
    seen_n   = seen_q | (4'b0001 << idx);
    conflict = seen_q[idx] && (table_q[idx] != s);
    count_n  = (count_q == MAX_C) ? count_q : count_q + 1'b1;
  end

  tt_classify u_classify (
    .code    (table_n),
    .gate_id (cls_id)
  );

  // Next state: clear first, then error > done > timeout
  always_comb begin
    state_d     = state_q;
    table_d     = table_q;
    seen_d      = seen_q;
    count_d     = count_q;
    func_code_d = func_code_q;
    gate_id_d   = gate_id_q;
    if (clear) begin
      state_d     = S_CAPTURE;
      table_d     = '0;
      seen_d      = '0;
      count_d     = '0;
      func_code_d = '0;
      gate_id_d   = '0;
    end else if (accept) begin
      count_d = count_n;
      if (conflict) begin
        state_d = S_ERROR;
      end else begin
        table_d = table_n;
        seen_d  = seen_n;
        if (seen_n == 4'hF) begin
          state_d     = S_DONE;
          func_code_d = table_n;
          gate_id_d   = cls_id;
        end else if (count_n == MAX_C) begin
          state_d = S_TIMEOUT;
        end
      end
    end
  end

  // State and capture registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_CAPTURE;
      table_q     <= '0;
      seen_q      <= '0;
      count_q     <= '0;
      func_code_q <= '0;
      gate_id_q   <= '0;
    end else begin
      state_q     <= state_d;
      table_q     <= table_d;
      seen_q      <= seen_d;
      count_q     <= count_d;
      func_code_q <= func_code_d;
      gate_id_q   <= gate_id_d;
    end
  end

  assign done      = (state_q == S_DONE);
  assign error     = (state_q == S_ERROR);
  assign timeout   = (state_q == S_TIMEOUT);
  assign func_code = func_code_q;
  assign gate_id   = gate_id_q;

endmodule

// File: tb/tb_truth_table_identifier.sv
// Scoreboard bench for truth_table_identifier.
// Stimulus queues expected verdicts; a monitor checks them.
module tb_truth_table_identifier;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic       a = 1'b0;
  logic       b = 1'b0;
  logic       s = 1'b0;
  logic       in_ready;
  logic       done;
  logic [3:0] func_code;
  logic [2:0] gate_id;
  logic       error;
  logic       timeout;

  typedef struct packed {
    logic       d;
    logic       e;
    logic       t;
    logic [3:0] fc;
    logic [2:0] gid;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  logic prev_any = 1'b0;

  truth_table_identifier #(
    .MAX_SAMPLES (16),
    .CNT_W       (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .s         (s),
    .done      (done),
    .func_code (func_code),
    .gate_id   (gate_id),
    .error     (error),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, req);
    end
  endtask

  // Monitor: pop an expectation whenever a verdict flag rises
  always @(negedge clk) begin
    logic any;
    exp_t e;
    any = done | error | timeout;
    if (any && !prev_any) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected verdict: d=%0b e=%0b t=%0b",
                 done, error, timeout);
      end else begin
        e = exp_q.pop_front();
        chk("mon done", done, e.d);
        chk("mon error", error, e.e);
        chk("mon timeout", timeout, e.t);
        chk("mon func_code", func_code, e.fc);
        chk("mon gate_id", gate_id, e.gid);
      end
    end
    prev_any <= any;
  end

  task automatic expect_v(input logic d, input logic er,
                          input logic t, input logic [3:0] fc,
                          input logic [2:0] gid);
    exp_t e;
    e.d = d; e.e = er; e.t = t; e.fc = fc; e.gid = gid;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic ia, input logic ib, input logic is);
    a = ia; b = ib; s = is;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic send_code(input logic [3:0] code);
    for (int i = 0; i < 4; i++) begin
      logic [1:0] ix;
      ix = 2'(i);
      send(ix[1], ix[0], code[i]);
    end
  endtask

  logic [3:0] codes[5] = '{4'h8, 4'hE, 4'h7, 4'h1, 4'h9};
  logic [2:0] gids[5]  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd6};

  initial begin
    #12 rst_n = 1'b1;
    @(posedge clk); #1;

    chk("rst in_ready", in_ready, 1);
    chk("rst done", done, 0);
    chk("rst error", error, 0);
    chk("rst timeout", timeout, 0);
    chk("rst func_code", func_code, 0);
    chk("rst gate_id", gate_id, 0);

    send(0, 0, 0); send(0, 1, 1); send(1, 0, 0);
    chk("andn early done", done, 0);
    expect_v(1, 0, 0, 4'h2, 3'd7);
    send(1, 1, 0);
    chk("andn latency", done, 1);
    chk("done in_ready", in_ready, 0);
    do_clear();

    send(1, 1, 0); send(0, 0, 0); send(0, 0, 0);
    send(1, 0, 1); send(0, 0, 0);
    chk("xor partial", done, 0);
    expect_v(1, 0, 0, 4'h6, 3'd5);
    send(0, 1, 1);
    do_clear();

    send(0, 1, 1);
    expect_v(0, 1, 0, 4'h0, 3'd0);
    send(0, 1, 0);
    chk("err in_ready", in_ready, 0);
    chk("err func_code", func_code, 0);
    send(1, 1, 1);
    chk("err sticky", error, 1);
    do_clear();
    chk("clr error", error, 0);
    chk("clr done", done, 0);
    chk("clr in_ready", in_ready, 1);

    expect_v(1, 0, 0, 4'hA, 3'd0);
    send_code(4'hA);
    do_clear();

    send(1, 1, 1); send(1, 0, 1); send(0, 1, 1);
    a = 0; b = 0; s = 1; in_valid = 1'b1;
    do_clear();
    in_valid = 1'b0;
    for (int i = 0; i < 15; i++) send(0, i[0], 0);
    chk("to early", timeout, 0);
    expect_v(0, 0, 1, 4'h0, 3'd0);
    send(0, 1, 0);
    chk("to latency", timeout, 1);
    a = 1; b = 1; s = 0; in_valid = 1'b1;
    #1;
    chk("to in_ready", in_ready, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("to sticky", timeout, 1);
    chk("to no done", done, 0);
    do_clear();

    a = 0; b = 0; s = 1; in_valid = 1'b1;
    do_clear();
    in_valid = 1'b0;
    send(0, 1, 0); send(1, 0, 0); send(1, 1, 1);
    chk("drop no done", done, 0);
    expect_v(1, 0, 0, 4'h8, 3'd1);
    send(0, 0, 0);
    do_clear();

    for (int g = 0; g < 5; g++) begin
      expect_v(1, 0, 0, codes[g], gids[g]);
      send_code(codes[g]);
      do_clear();
    end

    send(0, 0, 0); send(0, 1, 0); send(1, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst in_ready", in_ready, 1);
    chk("async rst done", done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(1, 1, 1); send(0, 0, 0);
    chk("rst restart no done", done, 0);
    chk("rst restart no err", error, 0);

    repeat (4) @(posedge clk);
    chk("queue drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
